// File: rtl/mat_row_sequencer_if.sv
// Bundle of the sequencer's job-control, RAM and compute-unit channels.
// The master modport is the sequencer side; slave is the environment side.
interface mat_row_sequencer_if #(
    parameter int unsigned DATA_LEN     = 32,
    parameter int unsigned N            = 8,
    parameter int unsigned ADDRESS_SIZE = 4
);
    localparam int unsigned ROW_W = DATA_LEN * N;

    logic                    i_start;
    logic [ADDRESS_SIZE-1:0] i_src_base;
    logic [ADDRESS_SIZE-1:0] i_dst_base;
    logic [ADDRESS_SIZE:0]   i_num_rows;
    logic                    o_busy;
    logic                    o_done;
    logic [ADDRESS_SIZE-1:0] o_mem_read_address;
    logic [ROW_W-1:0]        i_mem_read_data;
    logic [ADDRESS_SIZE-1:0] o_mem_write_address;
    logic [ROW_W-1:0]        o_mem_write_data;
    logic                    o_mem_wr_en;
    logic [ROW_W-1:0]        o_row_data;
    logic                    o_row_valid;
    logic                    i_row_ready;
    logic [ROW_W-1:0]        i_res_data;
    logic                    i_res_valid;
    logic                    o_res_ready;

    modport master (
        input  i_start, i_src_base, i_dst_base, i_num_rows,
        input  i_mem_read_data, i_row_ready, i_res_data, i_res_valid,
        output o_busy, o_done, o_mem_read_address, o_mem_write_address,
        output o_mem_write_data, o_mem_wr_en, o_row_data, o_row_valid, o_res_ready
    );

    modport slave (
        output i_start, i_src_base, i_dst_base, i_num_rows,
        output i_mem_read_data, i_row_ready, i_res_data, i_res_valid,
        input  o_busy, o_done, o_mem_read_address, o_mem_write_address,
        input  o_mem_write_data, o_mem_wr_en, o_row_data, o_row_valid, o_res_ready
    );
endinterface

// File: rtl/mat_row_sequencer.sv
// Walks a block of RAM rows through a row-wise compute unit and writes each
// result row back; sole owner of the RAM read and write ports.
module mat_row_sequencer #(
    parameter int unsigned DATA_LEN     = 32,
    parameter int unsigned N            = 8,
    parameter int unsigned ADDRESS_SIZE = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    mat_row_sequencer_if.master bus
);
    localparam int unsigned AW    = ADDRESS_SIZE;
    localparam int unsigned IDX_W = ADDRESS_SIZE + 1;
    localparam int unsigned ROW_W = DATA_LEN * N;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_SEND, S_RES, S_WR, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [ROW_W-1:0] wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic [ROW_W-1:0] row_data_q, row_data_d;
    logic             row_valid_q, row_valid_d;
    logic             res_ready_q, res_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and next-output logic; strobes (wr_en, done) default low.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        row_data_d  = row_data_q;
        row_valid_d = row_valid_q;
        res_ready_d = res_ready_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    src_d = bus.i_src_base;
                    dst_d = bus.i_dst_base;
                    cnt_d = bus.i_num_rows;
                    idx_d = '0;
                    if (bus.i_num_rows == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_RD;
                        rd_addr_d = bus.i_src_base;
                    end
                end
            end
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                row_data_d  = bus.i_mem_read_data;
                row_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (bus.i_row_ready) begin
                    row_valid_d = 1'b0;
                    res_ready_d = 1'b1;
                    state_d     = S_RES;
                end
            end
            S_RES: begin
                if (bus.i_res_valid) begin
                    res_ready_d = 1'b0;
                    wr_data_d   = bus.i_res_data;
                    wr_addr_d   = AW'(dst_q + idx_q[AW-1:0]);
                    wr_en_d     = 1'b1;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                // The write lands at the end of this cycle, so the next read sees it.
                idx_d = idx_q + IDX_W'(1);
                if (idx_d == cnt_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_RD;
                    rd_addr_d = AW'(src_q + idx_d[AW-1:0]);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_busy              = busy_q;
    assign bus.o_done              = done_q;
    assign bus.o_mem_read_address  = rd_addr_q;
    assign bus.o_mem_write_address = wr_addr_q;
    assign bus.o_mem_write_data    = wr_data_q;
    assign bus.o_mem_wr_en         = wr_en_q;
    assign bus.o_row_data          = row_data_q;
    assign bus.o_row_valid         = row_valid_q;
    assign bus.o_res_ready         = res_ready_q;
endmodule

// File: doc/mat_row_sequencer.md
Name: mat_row_sequencer

Overview:
- Sequences one row-memory instance (16 rows x 256 bits, 1-cycle registered read, 1-cycle synchronous write) through a per-row compute unit.
- On start: reads rows src_base..src_base+count-1, hands each row to the compute unit over a valid/ready channel, accepts one result row per source row, writes it to dst_base+idx.
- Sits between the matrix row RAM and the row-wise arithmetic unit. It is the only master of the RAM's read and write ports.

Parameters:
- DATA_LEN, 32, bits per element
- N, 8, elements per row (row width DATA_LEN*N = 256)
- ADDRESS_SIZE, 4, RAM row-address width (16 rows)

Ports:
- i_clk  in  1  clock; all logic on posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request; sampled only in IDLE
- i_src_base  in  ADDRESS_SIZE  first source row; latched on accepted start
- i_dst_base  in  ADDRESS_SIZE  first destination row; latched on accepted start
- i_num_rows  in  ADDRESS_SIZE+1  rows to process (0..16); latched on accepted start
- o_busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
- o_done  out  1  one-cycle pulse when the job completes
- o_mem_read_address  out  ADDRESS_SIZE  RAM read address
- i_mem_read_data  in  DATA_LEN*N  RAM registered read data
- o_mem_write_address  out  ADDRESS_SIZE  RAM write address
- o_mem_write_data  out  DATA_LEN*N  RAM write data
- o_mem_wr_en  out  1  RAM write enable
- o_row_data  out  DATA_LEN*N  row to compute unit
- o_row_valid  out  1  row valid
- i_row_ready  in  1  compute unit accepts row
- i_res_data  in  DATA_LEN*N  result row
- i_res_valid  in  1  result valid
- o_res_ready  out  1  sequencer accepts result

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; every output and internal register (idx, latched bases, count, row and result holding registers) is 0. Reset mid-job abandons the job. RAM rows already written stay written. No o_done pulse.
- All outputs are registered.
- States and transitions:
  - IDLE: i_start=1 latches bases and count and sets idx=0. Goes to DONE if count=0, else to RD.
  - RD: o_mem_read_address = src_base+idx, held for this cycle. Go to WAIT.
  - WAIT: RAM output is valid this cycle. Capture i_mem_read_data into o_row_data and set o_row_valid=1. Go to SEND.
  - SEND: hold o_row_data and o_row_valid stable until a posedge with i_row_ready=1. At that edge, clear o_row_valid, set o_res_ready=1, go to RES.
  - RES: hold o_res_ready=1 until a posedge with i_res_valid=1. At that edge, clear o_res_ready and register o_mem_write_data=i_res_data, o_mem_write_address=dst_base+idx, o_mem_wr_en=1. Go to WR.
  - WR: the write commits at the end of this cycle. Clear o_mem_wr_en next cycle and increment idx. If idx+1 == count go to DONE, else go to RD.
  - DONE: o_done=1 for exactly one cycle, o_busy=1. Go to IDLE. o_busy=0 in IDLE.
- Latency: minimum 5 cycles per row (RD, WAIT, SEND, RES, WR) when i_row_ready and i_res_valid are already high. A job of k rows takes 5k+1 cycles from the start edge to the o_done cycle.
- Address arithmetic: src_base+idx and dst_base+idx are computed modulo 2^ADDRESS_SIZE, so they wrap 15 -> 0.
- count=16 processes all 16 rows. idx is ADDRESS_SIZE+1 bits wide.
- Overlapping src/dst ranges are legal. The write in WR completes before the next RD edge, so a later read of a just-written row returns the new data.
- i_start while not IDLE is ignored. i_res_valid outside RES is ignored; no result is buffered. i_row_ready outside SEND is ignored.
- Inputs latched at start may change during the job without effect.
- At most one RAM access per cycle; read and write are never issued in the same cycle.

Test Plan:
- RAM preloaded rows 0-7 with element j of row r = 8r+j. Start src=0, dst=8, count=8. Compute unit returns row+1 per element with ready/valid always high. Required: rows 8-15 hold 8r+j+1, o_done pulses exactly 41 cycles after the start edge, o_busy is high throughout.
- Same job with i_row_ready low for 3 cycles in SEND of row 2. Required: o_row_data stays stable at row-2 data, o_row_valid stays high, no RAM access occurs during the stall, and the final contents are identical to the first scenario.
- src=14, dst=6, count=4. Required: reads 14,15,0,1 and writes 6,7,8,9 in order (wrap-around).
- count=0. Required: o_done pulses on the cycle after the start edge, with no o_mem_wr_en and no o_row_valid.
- Overlap: src=0, dst=1, count=3, compute returns data unchanged. Required: rows 1-3 all end equal to the original row 0 (read-after-write).
- Assert i_rst_n=0 during RES of row 3. Required: all outputs are 0 immediately, rows 8-10 are written, row 11 is unchanged. A new start afterwards runs normally.
